fn_result_collect: RTL and testbench

FN_RESULT_COLLECT -- requirements
Module: fn_result_collect

---
 rtl/fn_pkg.sv | 14 +
 rtl/fn_result_fifo.sv | 63 ++++++
 rtl/fn_result_collect.sv | 114 +++++++++++
 tb/tb_fn_result_collect.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fn_pkg.sv
// Shared definitions for the result-collection block: FSM state type and
// default sizing constants.
package fn_pkg;

    localparam int FN_WIDTH = 8;
    localparam int FN_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } fn_state_t;

endpackage

// File: rtl/fn_result_fifo.sv
// Result-word FIFO: register-array storage, wrapping read/write pointers and
// occupancy. The head word is presented directly from the storage registers.
module fn_result_fifo
    import fn_pkg::*;
#(
    parameter int WIDTH = FN_WIDTH,
    parameter int DEPTH = FN_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;

    // Storage carries no reset; empty slots are masked at the output instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_next;
        end
    end

    assign level   = level_reg;
    assign rd_data = (level_reg != '0) ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/fn_result_collect.sv
// Collects function-stage result words into a FIFO with flush/drain control.
// Define FN_RESULT_COLLECT_ACC_EN to build the running-sum accumulator on acc.
module fn_result_collect
    import fn_pkg::*;
#(
    parameter int WIDTH = FN_WIDTH,
    parameter int DEPTH = FN_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic                     flush_done,
    output logic [$clog2(DEPTH):0]   level,
    output logic [2*WIDTH-1:0]       acc
);

    localparam int LW = $clog2(DEPTH) + 1;

    fn_state_t     state_reg;
    fn_state_t     state_next;
    logic          run_reg;
    logic          push;
    logic          pop;
    logic [LW-1:0] level_next;

    // run_reg keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    assign in_ready   = run_reg && (level < LW'(DEPTH)) && (state_reg != DRAIN);
    assign out_valid  = (level != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign flush_done = (state_reg == DRAIN) && (level == '0);

    fn_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .wr_data    (in_data),
        .rd_data    (out_data),
        .level      (level),
        .level_next (level_next)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (flush) begin
                    state_next = DRAIN;
                end else if (push) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (flush) begin
                    state_next = DRAIN;
                end else if (level_next == '0) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (level == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef FN_RESULT_COLLECT_ACC_EN
    logic [2*WIDTH-1:0] acc_reg;

    // Intake is closed in DRAIN, so clearing on flush_done never drops a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (flush_done) begin
            acc_reg <= '0;
        end else if (push) begin
            acc_reg <= acc_reg + (2*WIDTH)'(in_data);
        end
    end

    assign acc = acc_reg;
`else
    assign acc = '0;
`endif

endmodule

// File: tb/tb_fn_result_collect.sv
// Self-checking bench for fn_result_collect: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fn_result_collect;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        flush;
    logic        flush_done;
    logic [2:0]  level;
    logic [15:0] acc;

    always #5 clk = ~clk;

    fn_result_collect dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flush      (flush),
        .flush_done (flush_done),
        .level      (level),
        .acc        (acc)
    );

    // Reference model: contents as a queue, a draining flag, a running sum.
    logic [7:0]  q[$];
    bit          m_run;
    bit          m_drain;
    logic [15:0] m_acc;
    int          pushes;
    int          checks;
    int          failures;
    int          txn;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (txn %0d)", name, act, exp, txn);
        end
    endtask

    function automatic logic [15:0] exp_acc();
`ifdef FN_RESULT_COLLECT_ACC_EN
        return m_acc;
`else
        return 16'h0;
`endif
    endfunction

    task automatic compare_all();
        bit         e_rdy;
        logic [7:0] e_data;
        e_rdy  = m_run && (q.size() < DEPTH) && !m_drain;
        e_data = (q.size() != 0) ? q[0] : 8'h00;
        chk("in_ready",   64'(in_ready),   64'(e_rdy));
        chk("out_valid",  64'(out_valid),  64'(q.size() != 0));
        chk("out_data",   64'(out_data),   64'(e_data));
        chk("level",      64'(level),      64'(q.size()));
        chk("flush_done", 64'(flush_done), 64'(m_drain && q.size() == 0));
        chk("acc",        64'(acc),        64'(exp_acc()));
    endtask

    task automatic model_reset();
        q.delete();
        m_run   = 1'b0;
        m_drain = 1'b0;
        m_acc   = 16'h0;
    endtask

    task automatic model_edge();
        bit rdy;
        bit do_push;
        bit do_pop;
        bit done;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rdy     = m_run && (q.size() < DEPTH) && !m_drain;
        do_push = in_valid && rdy;
        do_pop  = (q.size() != 0) && out_ready;
        done    = m_drain && (q.size() == 0);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back(in_data);
            m_acc = m_acc + 16'(in_data);
            pushes++;
        end
        if (done) begin
            m_drain = 1'b0;
            m_acc   = 16'h0;
        end else if (flush && !m_drain) begin
            m_drain = 1'b1;
        end
        m_run = 1'b1;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at negedge.
    task automatic cycle(bit v, logic [7:0] d, bit ordy, bit fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        txn++;
        $display("txn %0d: v=%0b d=%02h ordy=%0b fl=%0b | rdy=%0b ov=%0b od=%02h lvl=%0d fd=%0b acc=%04h",
                 txn, v, d, ordy, fl, in_ready, out_valid, out_data, level, flush_done, acc);
        compare_all();
    endtask

    task automatic apply_reset(int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rdy_after_reset", 64'(in_ready), 64'(1));
    endtask

    initial begin
        int guard;
        checks = 0; failures = 0; txn = 0; pushes = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; flush = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset(2);

        // Single push latency and first accumulation.
        cycle(1'b1, 8'h2A, 1'b0, 1'b0);
        chk("lit_ov_2a",   64'(out_valid), 64'(1));
        chk("lit_od_2a",   64'(out_data),  64'(8'h2A));
        chk("lit_lvl_2a",  64'(level),     64'(1));
`ifdef FN_RESULT_COLLECT_ACC_EN
        chk("lit_acc_2a",  64'(acc),       64'(16'h002A));
`endif

        // Fill to DEPTH, then a refused fifth word.
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        chk("lit_full_rdy", 64'(in_ready), 64'(0));
        chk("lit_full_lvl", 64'(level),    64'(4));
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        chk("lit_refused_lvl", 64'(level),    64'(4));
        chk("lit_refused_od",  64'(out_data), 64'(8'h2A));

        // Simultaneous push and pop at level 2.
        apply_reset(1);
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0);
        cycle(1'b1, 8'hA3, 1'b1, 1'b0);
        chk("lit_pp_lvl", 64'(level),    64'(2));
        chk("lit_pp_od",  64'(out_data), 64'(8'hA2));
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lit_pp_od2", 64'(out_data), 64'(8'hA3));

        // Accumulator wrap with continuous flow.
        apply_reset(1);
        pushes = 0;
        guard  = 0;
        while (pushes < 257 && guard < 1000) begin
            cycle(1'b1, 8'hFF, 1'b1, 1'b0);
            guard++;
        end
        chk("push_count_257", 64'(pushes), 64'(257));
`ifdef FN_RESULT_COLLECT_ACC_EN
        chk("lit_acc_ffff", 64'(acc), 64'(16'hFFFF));
`endif
        cycle(1'b1, 8'hFF, 1'b1, 1'b0);
`ifdef FN_RESULT_COLLECT_ACC_EN
        chk("lit_acc_fe", 64'(acc), 64'(16'h00FE));
`endif
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush at level 3 with draining output.
        apply_reset(1);
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 8'h03, 1'b0, 1'b0);
        cycle(1'b1, 8'h04, 1'b1, 1'b1);
        chk("lit_drain_rdy", 64'(in_ready), 64'(0));
        chk("lit_drain_lvl", 64'(level),    64'(3));
        cycle(1'b1, 8'h05, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lit_fd_pulse", 64'(flush_done), 64'(1));
        chk("lit_fd_lvl",   64'(level),      64'(0));
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lit_fd_end", 64'(flush_done), 64'(0));
        chk("lit_fd_acc", 64'(acc),        64'(0));
        chk("lit_fd_rdy", 64'(in_ready),   64'(1));

        // Flush with an empty FIFO.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("lit_empty_fd", 64'(flush_done), 64'(1));
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset mid-stream at level 2.
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("lit_rst_ov",  64'(out_valid), 64'(0));
        chk("lit_rst_acc", 64'(acc),       64'(0));
        chk("lit_rst_lvl", 64'(level),     64'(0));
        @(negedge clk);
        apply_reset(1);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                apply_reset(1);
            end else begin
                cycle(1'($urandom_range(0, 2) != 0), 8'($urandom),
                      1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
